// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART controller and its bit timer.
package uart_ctrl_pkg;

  localparam logic [1:0] ADDR_TXD = 2'd0;
  localparam logic [1:0] ADDR_RXD = 2'd1;
  localparam logic [1:0] ADDR_CON = 2'd2;

  localparam int unsigned CON_TX_IRQ_EN  = 0;
  localparam int unsigned CON_RX_IRQ_EN  = 1;
  localparam int unsigned CON_TX_DONE    = 2;
  localparam int unsigned CON_RX_DONE    = 3;
  localparam int unsigned CON_TX_BUSY    = 4;
  localparam int unsigned CON_FRAME_ERR  = 5;
  localparam int unsigned CON_RX_OVERRUN = 6;
  localparam int unsigned CON_TX_OVERRUN = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, pulses at the half and full points.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned CNT_W        = 14
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign half_o = (cnt_q == HalfCnt);
  assign full_o = (cnt_q == FullCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || full_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: RX/TX frame sequencers, TXD/RXD/CON registers and a level interrupt.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned CNT_W        = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  input  logic [1:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  logic sync1_q, rxs_q;
  uart_state_e rx_st_q, rx_st_d, tx_st_q, tx_st_d;
  logic [2:0] rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic [7:0] rx_sh_q, rx_sh_d, rxd_q, rxd_d, txd_q;
  logic rx_clr, rx_half, rx_full, rx_ok, rx_ferr;
  logic tx_clr, tx_half_unused, tx_full, tx_fin, tx_busy;
  logic tx_irq_en_q, rx_irq_en_q, tx_done_q, rx_done_q, frame_err_q, rx_ovr_q, tx_ovr_q, irq_q;
  logic tx_done_d, rx_done_d, frame_err_d, rx_ovr_d, tx_ovr_d, irq_d;
  logic txd_wr, con_wr, rxd_rd;
  logic [7:0] con;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_rx_timer (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (rx_clr),
    .half_o(rx_half),
    .full_o(rx_full)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tx_timer (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (tx_clr),
    .half_o(tx_half_unused),
    .full_o(tx_full)
  );

  assign txd_wr  = wr_en && (addr == ADDR_TXD);
  assign con_wr  = wr_en && (addr == ADDR_CON);
  assign rxd_rd  = rd_en && (addr == ADDR_RXD);
  assign tx_busy = (tx_st_q != IDLE);

  // After the start-bit midpoint the timer is re-zeroed, so every full pulse lands mid-bit.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_clr   = 1'b0;
    rx_ok    = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rx_st_q)
      IDLE: begin
        rx_clr = 1'b1;
        if (!rxs_q) rx_st_d = START;
      end
      START: begin
        if (rx_half) begin
          if (!rxs_q) begin
            rx_st_d  = DATA;
            rx_clr   = 1'b1;
            rx_idx_d = 3'd0;
          end else begin
            rx_st_d = IDLE;
          end
        end
      end
      DATA: begin
        if (rx_full) begin
          rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_st_d = STOP;
        end
      end
      STOP: begin
        if (rx_full) begin
          rx_st_d = IDLE;
          rx_ok   = rxs_q;
          rx_ferr = !rxs_q;
        end
      end
    endcase
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_idx_d = tx_idx_q;
    tx_clr   = 1'b0;
    tx_fin   = 1'b0;
    dout     = 1'b1;
    unique case (tx_st_q)
      IDLE: begin
        tx_clr = 1'b1;
        if (txd_wr) tx_st_d = START;
      end
      START: begin
        dout = 1'b0;
        if (tx_full) begin
          tx_st_d  = DATA;
          tx_idx_d = 3'd0;
        end
      end
      DATA: begin
        dout = txd_q[tx_idx_q];
        if (tx_full) begin
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_st_d = STOP;
        end
      end
      STOP: begin
        if (tx_full) begin
          tx_st_d = IDLE;
          tx_fin  = 1'b1;
        end
      end
    endcase
  end

  // Setting events take priority over clears landing in the same cycle.
  always_comb begin
    tx_done_d   = tx_fin | (tx_done_q & ~(con_wr & wdata[CON_TX_DONE]));
    rx_done_d   = rx_ok | (rx_done_q & ~rxd_rd);
    frame_err_d = rx_ferr | (frame_err_q & ~(con_wr & wdata[CON_FRAME_ERR]));
    rx_ovr_d    = (rx_ok & rx_done_q) | (rx_ovr_q & ~(con_wr & wdata[CON_RX_OVERRUN]));
    tx_ovr_d    = (txd_wr & tx_busy) | (tx_ovr_q & ~(con_wr & wdata[CON_TX_OVERRUN]));
    rxd_d       = rx_ok ? rx_sh_q : rxd_q;
    irq_d       = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_done_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rx_st_q     <= IDLE;
      rx_idx_q    <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_st_q     <= IDLE;
      tx_idx_q    <= 3'd0;
      txd_q       <= 8'h00;
      rxd_q       <= 8'h00;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovr_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= din;
      rxs_q       <= sync1_q;
      rx_st_q     <= rx_st_d;
      rx_idx_q    <= rx_idx_d;
      rx_sh_q     <= rx_sh_d;
      tx_st_q     <= tx_st_d;
      tx_idx_q    <= tx_idx_d;
      if (txd_wr && !tx_busy) txd_q <= wdata;
      rxd_q       <= rxd_d;
      if (con_wr) begin
        tx_irq_en_q <= wdata[CON_TX_IRQ_EN];
        rx_irq_en_q <= wdata[CON_RX_IRQ_EN];
      end
      tx_done_q   <= tx_done_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovr_q    <= tx_ovr_d;
      irq_q       <= irq_d;
    end
  end

  assign con = {tx_ovr_q, rx_ovr_q, frame_err_q, tx_busy,
                rx_done_q, tx_done_q, rx_irq_en_q, tx_irq_en_q};
  assign irq = irq_q;

  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_TXD: rdata = txd_q;
      ADDR_RXD: rdata = rxd_q;
      ADDR_CON: rdata = con;
      default:  rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl with a 16-clock bit period.
module tb_uart_ctrl;

  localparam int unsigned Cpb = 16;
  localparam logic [1:0] ATxd = 2'd0, ARxd = 2'd1, ACon = 2'd2, ARsv = 2'd3;
  localparam int SelRd = 0, SelDout = 1, SelIrq = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b1;
  logic       dout;
  logic [1:0] addr = 2'd0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       irq;

  uart_ctrl #(.CLKS_PER_BIT(Cpb), .CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout),
    .addr (addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int         sel_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [9:0] txq[$];
  logic [9:0] frame_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         final_req = 1'b0;
  bit         final_done = 1'b0;

  int         c_sel;
  logic [7:0] c_exp, c_act;
  string      c_name;
  logic [9:0] c_fr, c_fexp;

  // Checker: drains queued expectations and captured TX frames on every falling clock edge.
  always @(negedge clk) begin
    while (sel_q.size() != 0) begin
      c_sel  = sel_q.pop_front();
      c_exp  = exp_q.pop_front();
      c_name = name_q.pop_front();
      if (c_sel == SelRd)        c_act = rdata;
      else if (c_sel == SelDout) c_act = {7'b0, dout};
      else                       c_act = {7'b0, irq};
      n_cmp++;
      if (c_act !== c_exp) begin
        n_err++;
        $display("FAIL %s: got %02h, expected %02h", c_name, c_act, c_exp);
      end
    end
    while (frame_q.size() != 0) begin
      c_fr = frame_q.pop_front();
      n_cmp++;
      if (txq.size() == 0) begin
        n_err++;
        $display("FAIL tx_frame_unexpected: got %03h, expected none", c_fr);
      end else begin
        c_fexp = txq.pop_front();
        if (c_fr !== c_fexp) begin
          n_err++;
          $display("FAIL tx_frame: got %03h, expected %03h", c_fr, c_fexp);
        end
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      n_cmp++;
      if (txq.size() != 0) begin
        n_err++;
        $display("FAIL tx_frames_missing: got %0d outstanding, expected 0", txq.size());
      end
    end
  end

  // TX monitor: samples dout mid-bit from each falling edge; frames cut by reset are dropped.
  initial begin
    logic [9:0] fr;
    bit ab;
    @(posedge reset);
    forever begin
      @(negedge dout);
      ab = 1'b0;
      fr = '0;
      for (int i = 0; i < 10; i++) begin
        for (int k = 0; k < ((i == 0) ? Cpb / 2 : Cpb); k++) begin
          @(negedge clk);
          if (!reset) ab = 1'b1;
        end
        if (ab) break;
        fr[i] = dout;
      end
      if (ab) wait (reset === 1'b1);
      else frame_q.push_back(fr);
    end
  end

  task automatic chk(input int sel, input logic [7:0] e, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [7:0] e, input logic rd,
                        input string nm);
    addr  = a;
    rd_en = rd;
    chk(SelRd, e, nm);
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = bits[i];
      cyc(Cpb);
    end
    din = 1'b1;
    cyc(20);
  endtask

  initial begin
    #1 reset = 1'b0;
    cyc(1);
    chk(SelDout, 8'h01, "reset_dout");
    chk(SelIrq, 8'h00, "reset_irq");
    rd_chk(ACon, 8'h00, 1'b0, "reset_con");
    rd_chk(ARxd, 8'h00, 1'b0, "reset_rxd");
    cyc(1);
    reset = 1'b1;
    cyc(2);

    // RX with rx_irq_en
    bus_write(ACon, 8'h02);
    send_frame(8'h04, 1'b1);
    chk(SelIrq, 8'h01, "rx_irq_set");
    rd_chk(ACon, 8'h0A, 1'b0, "rx_con_done");
    rd_chk(ARxd, 8'h04, 1'b1, "rx_rxd");
    rd_chk(ACon, 8'h02, 1'b0, "rx_con_cleared");
    chk(SelIrq, 8'h00, "rx_irq_cleared");

    // TX with tx_irq_en, frame length and latency
    bus_write(ACon, 8'h01);
    bus_write(ATxd, 8'hA5);
    txq.push_back(10'h34A);
    chk(SelDout, 8'h00, "tx_start_latency");
    cyc(159);
    rd_chk(ACon, 8'h11, 1'b0, "tx_busy_last_cycle");
    chk(SelDout, 8'h01, "tx_idle_after_frame");
    rd_chk(ACon, 8'h05, 1'b0, "tx_done_set");
    chk(SelIrq, 8'h01, "tx_irq_set");
    bus_write(ACon, 8'h05);
    rd_chk(ACon, 8'h01, 1'b0, "tx_done_w1c");
    chk(SelIrq, 8'h00, "tx_irq_cleared");

    // RX overrun
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    rd_chk(ARxd, 8'h32, 1'b0, "ovr_rxd");
    rd_chk(ACon, 8'h49, 1'b0, "ovr_con");
    rd_chk(ARsv, 8'h00, 1'b0, "reserved_read");
    rd_chk(ARxd, 8'h32, 1'b1, "ovr_rxd_read");
    bus_write(ACon, 8'h41);
    rd_chk(ACon, 8'h01, 1'b0, "ovr_w1c");

    // TX overrun: second write mid-frame is dropped
    bus_write(ATxd, 8'h5A);
    txq.push_back(10'h2B4);
    cyc(50);
    bus_write(ATxd, 8'hFF);
    rd_chk(ACon, 8'h91, 1'b0, "tx_ovr_busy");
    cyc(120);
    rd_chk(ACon, 8'h85, 1'b0, "tx_ovr_done");
    bus_write(ACon, 8'h84);
    rd_chk(ACon, 8'h00, 1'b0, "tx_ovr_w1c");

    // Glitch on din: no frame
    din = 1'b0;
    cyc(4);
    din = 1'b1;
    cyc(30);
    rd_chk(ACon, 8'h00, 1'b0, "glitch_con");
    rd_chk(ARxd, 8'h32, 1'b0, "glitch_rxd");

    // Stop bit low: frame error, RXD kept
    send_frame(8'h55, 1'b0);
    rd_chk(ARxd, 8'h32, 1'b0, "ferr_rxd");
    rd_chk(ACon, 8'h20, 1'b0, "ferr_con");
    bus_write(ACon, 8'h20);
    rd_chk(ACon, 8'h00, 1'b0, "ferr_w1c");

    // Reset during TX bit 3 (a 0 bit)
    bus_write(ATxd, 8'hC3);
    cyc(70);
    chk(SelDout, 8'h00, "midtx_bit3");
    cyc(1);
    reset = 1'b0;
    chk(SelDout, 8'h01, "midtx_reset_dout");
    rd_chk(ACon, 8'h00, 1'b0, "midtx_reset_con");
    rd_chk(ARxd, 8'h00, 1'b0, "midtx_reset_rxd");
    cyc(1);
    reset = 1'b1;
    cyc(20);
    bus_write(ATxd, 8'hC3);
    txq.push_back(10'h386);
    chk(SelDout, 8'h00, "post_reset_tx_start");
    cyc(170);
    rd_chk(ACon, 8'h04, 1'b0, "post_reset_tx_done");
    chk(SelIrq, 8'h00, "post_reset_irq_masked");

    cyc(5);
    final_req = 1'b1;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Memory-mapped UART controller for the pipelined MIPS CPU.
- Sequences the serial receive path on din and the serial transmit path on dout at a fixed baud rate.
- Exposes TXD, RXD and CON registers to the CPU peripheral bus and raises an interrupt request.
- Sits beside the LED, digit and switch peripherals in the CPU top level.

Parameters:
- CLKS_PER_BIT, 10416: clock cycles per bit; 100 MHz clk at 9600 baud; bench uses 16.
- CNT_W, 14: width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial RX line; asynchronous; idle high.
- dout  out  1  serial TX line; idle high.
- addr  in  2  register select: 0=TXD, 1=RXD, 2=CON, 3=reserved.
- wr_en  in  1  bus write strobe; one cycle.
- rd_en  in  1  bus read strobe; one cycle.
- wdata  in  8  write data.
- rdata  out  8  read data; combinational from addr.
- irq  out  1  interrupt request; level.

Behaviour:
- Reset (reset=0, asynchronous):
  - RX and TX FSMs go to IDLE.
  - dout=1, irq=0, all CON bits 0, RXD=0.
  - din synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame; no flag is set.
- din passes through a 2-flop synchronizer; rxs is the synchronized value.
- RX FSM states:
  - IDLE: on rxs=0 go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1, if rxs=0 go to DATA with counter 0 and bit index 0; otherwise treat as a glitch and return to IDLE.
  - DATA: sample rxs at each count CLKS_PER_BIT-1 (mid-bit), LSB first, into a shift register. After bit index 7, go to STOP.
  - STOP: at mid-bit, if rxs=1 load RXD, set rx_done, and set rx_overrun if rx_done was already 1. If rxs=0, set frame_err and leave RXD unchanged. Return to IDLE in either case.
- TX FSM states:
  - IDLE: dout=1. A write to TXD latches wdata, sets tx_busy and goes to START.
  - START: dout=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: dout=1 for CLKS_PER_BIT cycles, then clear tx_busy, set tx_done and go to IDLE.
  - A TXD write while tx_busy=1 is ignored and sets tx_overrun.
- Latency: first dout falling edge occurs the cycle after the TXD write. A frame occupies exactly 10*CLKS_PER_BIT cycles.
- CON bit map:
  - [0] tx_irq_en, R/W.
  - [1] rx_irq_en, R/W.
  - [2] tx_done, write-1-to-clear.
  - [3] rx_done, read-only; cleared by an RXD read (rd_en with addr=1).
  - [4] tx_busy, read-only.
  - [5] frame_err, write-1-to-clear.
  - [6] rx_overrun, write-1-to-clear.
  - [7] tx_overrun, write-1-to-clear.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_done); registered, one cycle after the flag changes.
- Simultaneous events:
  - An RXD read in the same cycle as an RX completion leaves rx_done=1 with RXD holding the new byte.
  - A W1C write in the same cycle as the flag-setting event leaves the flag set (set wins).
- Reads of addr=3 return 0. Writes to addr=1 or addr=3 are ignored.
- RX and TX operate fully independently; full-duplex is supported.

Decomposition:
- Shared package holds:
  - address constants ADDR_TXD, ADDR_RXD, ADDR_CON;
  - CON bit-index constants;
  - the FSM state encodings IDLE, START, DATA, STOP, shared by RX and TX.
- One sub-module, uart_bit_timer, instantiated twice (RX and TX): a counter with clear input and half/full-bit pulse outputs.
- Register file and interrupt logic stay in uart_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles with din=1 -> dout=1, irq=0, CON reads 0x00, RXD reads 0x00.
- RX, CLKS_PER_BIT=16: drive frame 0x04 on din (start 0, bits 0,0,1,0,0,0,0,0, stop 1) with rx_irq_en=1 -> RXD=0x04, CON[3]=1, irq=1 within 2 cycles of stop mid-bit. RXD read -> CON[3]=0, irq=0.
- TX: write CON=0x01, then TXD=0xA5 -> dout shows 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit; CON[4]=1 during the frame. Afterwards tx_done=1 and irq=1. Write CON=0x05 -> tx_done clears, irq=0.
- Overrun/busy: receive 0x31 then 0x32 without reading -> RXD=0x32, CON[6]=1. A second TXD write mid-frame -> frame unchanged, CON[7]=1.
- Errors: din low for 4 cycles then high -> no frame, RX back to IDLE. Frame with stop bit 0 -> CON[5]=1, RXD unchanged, rx_done unchanged.
- Reset mid-TX at bit 3 -> dout=1 immediately, tx_busy=0. A subsequent TXD write transmits normally.
